// File: rtl/mfp_spi_rx_pkg.sv
// mfp_spi_rx_pkg
//   Shared definitions for the ESP8266 serial-link receive peripheral
//   (mfp_ahb_spi_rx and its FIFO).
//   Register map (byte offsets): DATA 0x0, STAT 0x4, CTRL 0x8.
//   STAT layout:
//     [0]   empty
//     [7:1] FIFO word count, zero-extended
//     [8]   OVF, sticky overflow
//     [9]   PERR, sticky parity error (always 0 without SPI_RX_PARITY_EN)
//   CTRL layout:
//     [0] EN
//     [1] IRQ_EN
//     [2] write 1 to clear OVF
//     [3] write 1 to clear PERR
package mfp_spi_rx_pkg;

   localparam int WORD_W = 16;
   typedef logic [WORD_W-1:0] rx_word_t;

   localparam logic [3:0] OFF_DATA = 4'h0;
   localparam logic [3:0] OFF_STAT = 4'h4;
   localparam logic [3:0] OFF_CTRL = 4'h8;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_CNT_LSB = 1;
   localparam int STAT_CNT_W   = 7;
   localparam int STAT_OVF     = 8;
   localparam int STAT_PERR    = 9;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_OVF_CLR  = 2;
   localparam int CTRL_PERR_CLR = 3;

   // Word index of a byte address within the block.
   function automatic logic [1:0] reg_idx(input logic [3:0] addr);
      return addr[3:2];
   endfunction

endpackage

// File: rtl/mfp_ahb_spi_rx_if.sv
// mfp_ahb_spi_rx_if
//   AHB-Lite slave-side signal bundle for the link receive peripheral.
//   Signals:
//     HSEL   - slave select
//     HTRANS - transfer type
//     HADDR  - byte address within the block
//     HWRITE - 1 = write, 0 = read
//     HWDATA - write data, presented in the data phase
//     HRDATA - read data, presented in the data phase
//   Modports:
//     master - drives the request and receives HRDATA
//     slave  - receives the request and drives HRDATA
interface mfp_ahb_spi_rx_if;
   logic        HSEL;
   logic [1:0]  HTRANS;
   logic [3:0]  HADDR;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;

   modport master (output HSEL, output HTRANS, output HADDR, output HWRITE,
                   output HWDATA, input HRDATA);
   modport slave  (input HSEL, input HTRANS, input HADDR, input HWRITE,
                   input HWDATA, output HRDATA);
endinterface

// File: rtl/mfp_spi_rx_fifo.sv
// mfp_spi_rx_fifo
//   Synchronous word FIFO with a show-ahead head word: dout is the oldest
//   entry whenever the FIFO is not empty.
//   Ports:
//     clk, rst_n  - clock and asynchronous active-low reset
//     push, din   - write request and word
//     pop         - remove the head word; ignored when empty
//     dout        - head word
//     count       - number of stored words
//     full, empty - status flags
//   A push while full succeeds only when a pop happens in the same cycle.
module mfp_spi_rx_fifo
   import mfp_spi_rx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rx_word_t                 din,
   input  logic                     pop,
   output rx_word_t                 dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   rx_word_t      mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Pointers carry one extra MSB so that full and empty are distinguishable.
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // When full, a simultaneous push overwrites the slot being popped; the
   // old head has already been presented on dout in this cycle.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mfp_ahb_spi_rx.sv
// mfp_ahb_spi_rx
//   AHB-Lite slave that receives 16-bit words from the ESP8266 over a
//   two-wire link (SCLK_IN + SDI), MSB first, and buffers them in a FIFO.
//   Ports:
//     HCLK, HRESETn - bus clock and asynchronous active-low reset
//     ahb           - AHB-Lite slave bundle (HSEL/HTRANS/HADDR/HWRITE/HWDATA/HRDATA)
//     SCLK_IN, SDI  - link pins, asynchronous to HCLK
//     RX_IRQ        - level interrupt, IRQ_EN & FIFO not empty
//   Parameters:
//     FIFO_DEPTH - words buffered; power of two, >= 2, <= 64
//     TIMEOUT    - idle HCLK cycles before a partial frame is discarded
//   Configuration macro:
//     SPI_RX_PARITY_EN - frames carry a trailing even-parity bit (17 edges);
//     a bad frame is dropped and sets sticky PERR.
module mfp_ahb_spi_rx
   import mfp_spi_rx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   mfp_ahb_spi_rx_if.slave    ahb,
   input  logic               SCLK_IN,
   input  logic               SDI,
   output logic               RX_IRQ
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
`ifdef SPI_RX_PARITY_EN
   localparam int FRAME_BITS = WORD_W + 1;
`else
   localparam int FRAME_BITS = WORD_W;
`endif
   localparam int BC_W = $clog2(FRAME_BITS + 1);

   // ---------------- link synchronisers ----------------
   logic sclk_s1, sclk_s2, sclk_s3;
   logic sdi_s1, sdi_s2;
   logic rise;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         sdi_s1  <= 1'b0;
         sdi_s2  <= 1'b0;
      end else begin
         sclk_s1 <= SCLK_IN;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         sdi_s1  <= SDI;
         sdi_s2  <= sdi_s1;
      end
   end

   // SDI travels through the same two stages as SCLK, so sdi_s2 is the
   // data value that accompanied the clock edge being detected.
   assign rise = sclk_s2 & ~sclk_s3;

   // ---------------- deserialiser and idle timer ----------------
   logic                  en;
   logic                  irq_en;
   logic                  ovf;
   logic                  perr;
   logic [FRAME_BITS-2:0] shift_r;
   logic [BC_W-1:0]       bitcnt;
   logic [TMR_W-1:0]      idle_tmr;
   logic                  frame_done;
   logic                  word_ok;
   rx_word_t              rx_word;

   assign frame_done = en & rise & (bitcnt == BC_W'(FRAME_BITS - 1));

`ifdef SPI_RX_PARITY_EN
   // shift_r already holds the 16 data bits; the live bit is the parity bit.
   assign rx_word = shift_r;
   assign word_ok = ~(^shift_r ^ sdi_s2);
`else
   assign rx_word = {shift_r, sdi_s2};
   assign word_ok = 1'b1;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         bitcnt   <= '0;
         idle_tmr <= '0;
      end else if (!en) begin
         bitcnt   <= '0;
         idle_tmr <= '0;
      end else if (rise) begin
         idle_tmr <= '0;
         bitcnt   <= frame_done ? '0 : bitcnt + 1'b1;
      end else begin
         if (idle_tmr != TMR_W'(TIMEOUT)) idle_tmr <= idle_tmr + 1'b1;
         // A stalled sender leaves a partial frame; drop it so the next
         // word starts aligned.
         if (idle_tmr == TMR_W'(TIMEOUT) && bitcnt != '0) bitcnt <= '0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (en & rise) shift_r <= {shift_r[FRAME_BITS-3:0], sdi_s2};
   end

   // ---------------- FIFO ----------------
   logic             a_sel;
   logic             rd_pop;
   logic             push_req;
   logic             fifo_push;
   logic             ovf_evt;
   rx_word_t         fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   assign a_sel     = ahb.HSEL & ahb.HTRANS[1];
   // The pop takes effect at the edge that opens the read's data phase, the
   // same edge that loads HRDATA with the current head word.
   assign rd_pop    = a_sel & ~ahb.HWRITE & ~fifo_empty
                      & (reg_idx(ahb.HADDR) == reg_idx(OFF_DATA));
   assign push_req  = frame_done & word_ok;
   assign fifo_push = push_req & (~fifo_full | rd_pop);
   assign ovf_evt   = push_req & fifo_full & ~rd_pop;

   mfp_spi_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .push  (fifo_push),
      .din   (rx_word),
      .pop   (rd_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ---------------- AHB register file ----------------
   logic        d_wr;
   logic [1:0]  d_idx;
   logic        ctrl_wr;
   logic [31:0] rd_mux;
   logic [31:0] hrdata_r;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         d_wr  <= 1'b0;
         d_idx <= '0;
      end else begin
         d_wr  <= a_sel & ahb.HWRITE;
         d_idx <= reg_idx(ahb.HADDR);
      end
   end

   assign ctrl_wr = d_wr & (d_idx == reg_idx(OFF_CTRL));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         en     <= 1'b0;
         irq_en <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            en     <= ahb.HWDATA[CTRL_EN];
            irq_en <= ahb.HWDATA[CTRL_IRQ_EN];
         end
         // A new overflow wins over a clear in the same cycle.
         if (ovf_evt)                              ovf <= 1'b1;
         else if (ctrl_wr && ahb.HWDATA[CTRL_OVF_CLR]) ovf <= 1'b0;
      end
   end

`ifdef SPI_RX_PARITY_EN
   logic perr_evt;
   assign perr_evt = frame_done & ~word_ok;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         perr <= 1'b0;
      end else if (perr_evt) begin
         perr <= 1'b1;
      end else if (ctrl_wr && ahb.HWDATA[CTRL_PERR_CLR]) begin
         perr <= 1'b0;
      end
   end
`else
   logic unused_perr_clr;
   assign perr            = 1'b0;
   assign unused_perr_clr = ahb.HWDATA[CTRL_PERR_CLR];
`endif

   always_comb begin
      rd_mux = '0;
      case (reg_idx(ahb.HADDR))
         reg_idx(OFF_DATA): begin
            if (!fifo_empty) rd_mux[WORD_W-1:0] = fifo_dout;
         end
         reg_idx(OFF_STAT): begin
            rd_mux[STAT_EMPTY]                  = fifo_empty;
            rd_mux[STAT_CNT_LSB +: STAT_CNT_W]  = STAT_CNT_W'(fifo_count);
            rd_mux[STAT_OVF]                    = ovf;
            rd_mux[STAT_PERR]                   = perr;
         end
         reg_idx(OFF_CTRL): begin
            rd_mux[CTRL_EN]     = en;
            rd_mux[CTRL_IRQ_EN] = irq_en;
         end
         default: rd_mux = '0;
      endcase
   end

   // Captured at the address-phase edge so the value is stable for the whole
   // data phase; held between reads.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hrdata_r <= '0;
      end else if (a_sel && !ahb.HWRITE) begin
         hrdata_r <= rd_mux;
      end
   end

   assign ahb.HRDATA = hrdata_r;
   assign RX_IRQ     = irq_en & ~fifo_empty;

   logic unused_bus;
   assign unused_bus = &{1'b0, ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:4]};

endmodule

// File: tb/tb_mfp_ahb_spi_rx.sv
// tb_mfp_ahb_spi_rx
//   Scoreboard bench for mfp_ahb_spi_rx: each read pushes its expected
//   HRDATA into a queue, and a monitor pops and compares whenever a read
//   data phase is on the bus. Link frames are driven at SCLK period 20 HCLK.
module tb_mfp_ahb_spi_rx;

   localparam int TIMEOUT = 1024;
   localparam logic [3:0] A_DATA = 4'h0;
   localparam logic [3:0] A_STAT = 4'h4;
   localparam logic [3:0] A_CTRL = 4'h8;
   localparam logic [3:0] A_NONE = 4'hC;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;
   logic SCLK_IN = 1'b0;
   logic SDI     = 1'b0;
   logic RX_IRQ;

   mfp_ahb_spi_rx_if bus ();

   mfp_ahb_spi_rx #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .ahb     (bus),
      .SCLK_IN (SCLK_IN),
      .SDI     (SDI),
      .RX_IRQ  (RX_IRQ)
   );

   always #5 HCLK = ~HCLK;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // Expected STAT word: PERR[9], OVF[8], count[7:1], empty[0].
   function automatic logic [31:0] stat(input int cnt, input bit ovf, input bit perr);
      logic [31:0] v;
      v = 32'(cnt) << 1;
      v[0] = (cnt == 0);
      v[8] = ovf;
      v[9] = perr;
      return v;
   endfunction

   // Monitor: a read data phase follows every accepted read address phase.
   logic dph = 1'b0;
   always @(posedge HCLK) dph <= HRESETn & bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;

   always @(negedge HCLK) begin
      exp_t e;
      if (dph) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_read: HRDATA 0x%08h with nothing queued", bus.HRDATA);
         end else begin
            e = sb.pop_front();
            check(e.name, bus.HRDATA, e.exp);
         end
      end
   end

   // All tasks start and end on a falling HCLK edge.
   task automatic idle(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic ahb_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
      sb.push_back('{nm, exp});
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = a;
      bus.HWRITE = 1'b0;
      @(negedge HCLK);
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
   endtask

   task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = a;
      bus.HWRITE = 1'b1;
      @(negedge HCLK);
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HWDATA = d;
      @(negedge HCLK);
   endtask

   // Sends the low n bits of v MSB first. With rd_last set, a DATA read is
   // placed so its address-phase edge coincides with the last edge's push
   // (pin edge + 3 HCLK).
   task automatic send_bits(input logic [31:0] v, input int n, input bit rd_last,
                            input logic [31:0] rd_exp);
      for (int i = n - 1; i >= 0; i--) begin
         SDI     = v[i];
         SCLK_IN = 1'b0;
         idle(10);
         SCLK_IN = 1'b1;
         if (i == 0 && rd_last) begin
            idle(2);
            ahb_read(A_DATA, rd_exp, "data_read_at_push");
            idle(7);
         end else begin
            idle(10);
         end
      end
   endtask

   task automatic send_frame(input logic [15:0] w, input bit rd_last, input logic [31:0] rd_exp);
`ifdef SPI_RX_PARITY_EN
      send_bits({15'd0, w, ^w}, 17, rd_last, rd_exp);
`else
      send_bits({16'd0, w}, 16, rd_last, rd_exp);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HADDR  = 4'h0;
      bus.HWRITE = 1'b0;
      bus.HWDATA = 32'h0;

      // Reset state
      #1;
      check("reset_hrdata", bus.HRDATA, 32'h0);
      check("reset_irq", {31'd0, RX_IRQ}, 32'h0);
      idle(3);
      HRESETn = 1'b1;
      idle(1);
      ahb_read(A_STAT, stat(0, 0, 0), "reset_stat");
      ahb_read(A_CTRL, 32'h0, "reset_ctrl");

      // 1: single word
      ahb_write(A_CTRL, 32'h1);
      send_frame(16'hA55A, 0, 0);
      idle(2);
      ahb_read(A_STAT, stat(1, 0, 0), "t1_stat_one");
      ahb_read(A_DATA, 32'h0000A55A, "t1_data");
      ahb_read(A_STAT, stat(0, 0, 0), "t1_stat_empty");
      ahb_read(A_CTRL, 32'h1, "t1_ctrl");
      ahb_read(A_NONE, 32'h0, "t1_unmapped");

      // 2: overflow
      for (int w = 1; w <= 5; w++) send_frame(16'(w), 0, 0);
      idle(2);
      ahb_read(A_STAT, stat(4, 1, 0), "t2_stat_full_ovf");
      for (int w = 1; w <= 4; w++) ahb_read(A_DATA, 32'(w), "t2_data");
      ahb_read(A_DATA, 32'h0, "t2_data_empty");
      ahb_read(A_STAT, stat(0, 1, 0), "t2_stat_ovf_sticky");
      ahb_write(A_CTRL, 32'h5);
      ahb_read(A_STAT, stat(0, 0, 0), "t2_stat_ovf_cleared");

      // 3: partial frame discarded by timeout
      send_bits(32'h55, 7, 0, 0);
      idle(TIMEOUT + 5);
      send_frame(16'h1234, 0, 0);
      idle(2);
      ahb_read(A_STAT, stat(1, 0, 0), "t3_stat_one");
      ahb_read(A_DATA, 32'h1234, "t3_data");
      ahb_read(A_STAT, stat(0, 0, 0), "t3_stat_empty");

      // 4: push and pop in the same cycle while full
      send_frame(16'h0011, 0, 0);
      send_frame(16'h0022, 0, 0);
      send_frame(16'h0033, 0, 0);
      send_frame(16'h0044, 0, 0);
      send_frame(16'hBEEF, 1, 32'h0011);
      idle(2);
      ahb_read(A_STAT, stat(4, 0, 0), "t4_stat_full_no_ovf");
      ahb_read(A_DATA, 32'h0022, "t4_data");
      ahb_read(A_DATA, 32'h0033, "t4_data");
      ahb_read(A_DATA, 32'h0044, "t4_data");
      ahb_read(A_DATA, 32'hBEEF, "t4_data_last");
      ahb_read(A_STAT, stat(0, 0, 0), "t4_stat_empty");

      // 5: interrupt and reset mid-frame
      ahb_write(A_CTRL, 32'h3);
      check("t5_irq_idle", {31'd0, RX_IRQ}, 32'h0);
      send_frame(16'h5A5A, 0, 0);
      idle(2);
      check("t5_irq_set", {31'd0, RX_IRQ}, 32'h1);
      ahb_read(A_DATA, 32'h5A5A, "t5_data");
      check("t5_irq_clear", {31'd0, RX_IRQ}, 32'h0);
      send_frame(16'h0F0F, 0, 0);
      idle(2);
      check("t5_irq_before_rst", {31'd0, RX_IRQ}, 32'h1);
      ahb_read(A_STAT, stat(1, 0, 0), "t5_stat_before_rst");
      send_bits(32'hA5, 8, 0, 0);
      HRESETn = 1'b0;
      SCLK_IN = 1'b0;
      #1;
      check("t5_rst_hrdata", bus.HRDATA, 32'h0);
      check("t5_rst_irq", {31'd0, RX_IRQ}, 32'h0);
      idle(3);
      HRESETn = 1'b1;
      idle(2);
      ahb_read(A_STAT, stat(0, 0, 0), "t5_stat_after_rst");
      ahb_read(A_CTRL, 32'h0, "t5_ctrl_after_rst");
      ahb_write(A_CTRL, 32'h1);
      send_frame(16'hC3C3, 0, 0);
      idle(2);
      ahb_read(A_DATA, 32'hC3C3, "t5_data_after_rst");

`ifdef SPI_RX_PARITY_EN
      // 6: parity
      send_bits({15'd0, 16'h00FF, 1'b0}, 17, 0, 0);
      idle(2);
      ahb_read(A_DATA, 32'h00FF, "t6_parity_good");
      send_bits({15'd0, 16'h00FF, 1'b1}, 17, 0, 0);
      idle(2);
      ahb_read(A_STAT, stat(0, 0, 1), "t6_parity_bad_stat");
      ahb_write(A_CTRL, 32'h9);
      ahb_read(A_STAT, stat(0, 0, 0), "t6_perr_cleared");
`endif

      idle(3);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
